if_id_queue: RTL and testbench

- Small instruction queue between the fetch stage (PC register plus instruction memory read) and decode.
- Captures {pc, instruction} pairs with a valid/ready handshake and presents the oldest pair to decode.
- Absorbs decode stalls without losing in-flight fetches.
- Supports a single-cycle flush for redirects: branch/jump taken, which is when fetch's pc_sel is asserted.

---
 rtl/if_id_queue.sv | 95 +++++++++
 tb/tb_if_id_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Purpose : fetch-to-decode instruction queue holding {pc, inst} pairs in strict FIFO order, with single-cycle flush.
// Latency : 1 cycle minimum from push to head (no same-cycle bypass); a pop at full frees a slot visible next cycle.
// Backpressure: f_ready depends on fill level only (deasserted when full, never on d_ready); d_ready is ignored when empty.
//
// Ports:
//   clk, rst          - clock (rising edge) and asynchronous active-low reset
//   f_valid/f_ready   - fetch-side handshake; f_pc/f_inst carry the offered pair
//   flush             - discard stored entries and the pair offered this cycle (wins over push/pop)
//   d_valid/d_ready   - decode-side handshake; d_pc/d_inst show the head (0/NOP_INST when empty)
//   count             - number of stored entries, 0..DEPTH
module if_id_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [DWIDTH-1:0] NOP_INST = DWIDTH'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       f_valid,
    input  logic [AWIDTH-1:0]          f_pc,
    input  logic [DWIDTH-1:0]          f_inst,
    output logic                       f_ready,
    input  logic                       flush,
    output logic                       d_valid,
    output logic [AWIDTH-1:0]          d_pc,
    output logic [DWIDTH-1:0]          d_inst,
    input  logic                       d_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; contents need no reset because d_valid gates what decode sees.
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] inst_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    assign f_ready = (count_q != CW'(DEPTH));
    assign d_valid = (count_q != '0);
    assign count   = count_q;

    // Empty queue presents a harmless NOP so decode never sees stale or X data.
    assign d_pc    = d_valid ? pc_mem[rd_ptr_q]   : '0;
    assign d_inst  = d_valid ? inst_mem[rd_ptr_q] : NOP_INST;

    assign push = f_valid & f_ready & ~flush;
    assign pop  = d_valid & d_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= f_pc;
            inst_mem[wr_ptr_q] <= f_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
    logic        f_ready;
    logic        flush;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_inst;
    logic        d_ready;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int mcount = 0;

    // Scoreboard of expected {pc, inst} in push order.
    logic [63:0] sb[$];

    if_id_queue #(
        .AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_inst(f_inst), .f_ready(f_ready),
        .flush(flush),
        .d_valid(d_valid), .d_pc(d_pc), .d_inst(d_inst), .d_ready(d_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_d_valid"}, 64'(d_valid), 64'(0));
        chk({tag, "_f_ready"}, 64'(f_ready), 64'(1));
        chk({tag, "_count"},   64'(count),   64'(0));
        chk({tag, "_d_inst"},  64'(d_inst),  64'(NOP));
        chk({tag, "_d_pc"},    64'(d_pc),    64'(0));
    endtask

    // One clock cycle: drive at posedge+1, check head/flags at posedge+3,
    // advance the model on the edge, check count at posedge+1.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic dr, input logic fl);
        bit do_push;
        bit do_pop;
        f_valid = fv; f_pc = pc; f_inst = inst; d_ready = dr; flush = fl;
        #2;
        chk("f_ready", 64'(f_ready), 64'(mcount != DEPTH));
        chk("d_valid", 64'(d_valid), 64'(mcount != 0));
        if (sb.size() != 0) begin
            chk("d_pc",   64'(d_pc),   64'(sb[0][63:32]));
            chk("d_inst", 64'(d_inst), 64'(sb[0][31:0]));
        end else begin
            chk("d_pc_empty",   64'(d_pc),   64'(0));
            chk("d_inst_empty", 64'(d_inst), 64'(NOP));
        end
        do_push = fv && (mcount != DEPTH) && !fl;
        do_pop  = (mcount != 0) && dr && !fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                pops++;
            end
            if (do_push) sb.push_back({pc, inst});
        end
        mcount = sb.size();
        #1;
        chk("count", 64'(count), 64'(mcount));
    endtask

    initial begin
        rst = 1'b0; f_valid = 1'b0; f_pc = '0; f_inst = '0; d_ready = 1'b0; flush = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk_empty("in_reset");
        rst = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_empty("after_reset");

        // Fill with decode stalled; third offer must be refused
        cycle(1'b1, 32'h00, 32'hAAAA0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h04, 32'hAAAA0002, 1'b0, 1'b0);
        chk("full_count",   64'(count),   64'(2));
        chk("full_f_ready", 64'(f_ready), 64'(0));
        chk("full_d_pc",    64'(d_pc),    64'(32'h00));
        cycle(1'b1, 32'h08, 32'hAAAA0003, 1'b0, 1'b0);
        chk("full_hold_pc",   64'(d_pc),   64'(32'h00));
        chk("full_hold_inst", 64'(d_inst), 64'(32'hAAAA0001));

        // Drain in order
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_second", 64'(d_inst), 64'(32'hAAAA0002));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_empty("drained");
        chk("drain_pops", 64'(pops), 64'(2));

        // Streaming with wrap: 10 pairs, count stays at 1
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(i * 4), 32'hBBBB0000 | 32'(i), 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'(1));
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_pops", 64'(pops), 64'(12));
        chk_empty("stream_done");

        // Flush priority over push and pop
        cycle(1'b1, 32'h10, 32'hCCCC0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h14, 32'hCCCC0002, 1'b0, 1'b0);
        chk("preflush_count", 64'(count), 64'(2));
        cycle(1'b1, 32'h40, 32'hCCCC0040, 1'b1, 1'b1);
        chk_empty("flushed");
        cycle(1'b1, 32'h80, 32'hCCCC0080, 1'b0, 1'b0);
        chk("post_flush_head", 64'(d_pc), 64'(32'h80));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_empty("post_flush_drained");

        // Asynchronous reset between edges
        cycle(1'b1, 32'h100, 32'hDDDD0001, 1'b0, 1'b0);
        chk("pre_reset_count", 64'(count), 64'(1));
        f_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_empty("async_reset");
        sb.delete();
        mcount = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 32'h200, 32'hDDDD0002, 1'b0, 1'b0);
        chk("after_reset_head", 64'(d_pc), 64'(32'h200));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_empty("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
